// File: rtl/module_types.sv
// Shared types and constants for the BTB commit-side update path.
package module_types;

    localparam int unsigned BTB_ADDR_W     = 32;
    localparam int unsigned BTB_UPD_QDEPTH = 4;

    typedef struct packed {
        logic [BTB_ADDR_W-1:0] pc;
        logic [BTB_ADDR_W-1:0] target;
    } btb_upd_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } upd_state_e;

endpackage

// File: rtl/btb_upd_queue.sv
// Circular update queue with a pc match port: matching updates overwrite the
// queued target in place; the rest are appended in slot order.
module btb_upd_queue
    import module_types::*;
#(
    parameter int unsigned QDEPTH = BTB_UPD_QDEPTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                enq_valid_i,
    input  btb_upd_t [1:0]            enq_i,
    input  logic                      deq_i,
    output btb_upd_t                  head_o,
    output logic [$clog2(QDEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    btb_upd_t          mem_q [QDEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic              do_deq;
    logic [QDEPTH-1:0] live;
    logic [1:0]        hit;
    logic [1:0][PW-1:0] hit_idx;
    logic              same_pc;
    logic              v0, v1;
    logic              ovw0, ovw1;
    logic              alloc0, alloc1;

    assign do_deq = deq_i && (count_q != '0);

    // The head is excluded from matching when it leaves this cycle.
    always_comb begin
        live = '0;
        for (int unsigned j = 0; j < QDEPTH; j++) begin
            live[j] = (CW'(PW'(j) - head_q) < count_q) && !(do_deq && (PW'(j) == head_q));
        end
    end

    always_comb begin
        hit     = '0;
        hit_idx = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            for (int unsigned j = 0; j < QDEPTH; j++) begin
                if (live[j] && (mem_q[j].pc == enq_i[s].pc)) begin
                    hit[s]     = 1'b1;
                    hit_idx[s] = PW'(j);
                end
            end
        end
    end

    // Equal pcs in both slots collapse onto slot 1 (younger target wins).
    assign same_pc = enq_valid_i[0] && enq_valid_i[1] && (enq_i[0].pc == enq_i[1].pc);
    assign v0      = enq_valid_i[0] && !same_pc;
    assign v1      = enq_valid_i[1];
    assign ovw0    = v0 && hit[0];
    assign ovw1    = v1 && hit[1];
    assign alloc0  = v0 && !hit[0];
    assign alloc1  = v1 && !hit[1];

    always_comb begin
        head_d  = head_q + PW'(do_deq);
        tail_d  = tail_q + PW'(alloc0) + PW'(alloc1);
        count_d = count_q + CW'(alloc0) + CW'(alloc1) - CW'(do_deq);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ovw0)   mem_q[hit_idx[0]].target      <= enq_i[0].target;
        if (ovw1)   mem_q[hit_idx[1]].target      <= enq_i[1].target;
        if (alloc0) mem_q[tail_q]                 <= enq_i[0];
        if (alloc1) mem_q[tail_q + PW'(alloc0)]   <= enq_i[1];
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port controller: accepts two commit slots into a coalescing queue,
// drains one registered write per cycle and supports a drain handshake.
module btb_update_ctrl
    import module_types::*;
#(
    parameter int unsigned QDEPTH = BTB_UPD_QDEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               upd_valid,
    input  logic [1:0][31:0]         upd_pc,
    input  logic [1:0][31:0]         upd_target,
    output logic                     upd_ready,
    input  logic                     btb_stall,
    input  logic                     drain_req,
    output logic                     drain_done,
    output logic                     btb_w_en,
    output logic [31:0]              btb_commit_pc,
    output logic [31:0]              btb_target_addr,
    output logic [$clog2(QDEPTH):0]  q_count
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    upd_state_e        state_q, state_d;
    btb_upd_t [1:0]    enq;
    btb_upd_t          head;
    logic [CW-1:0]     count;
    logic              pop;
    logic              w_en_q;
    logic [31:0]       pc_q, tgt_q;

    always_comb begin
        enq = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            enq[i].pc     = upd_pc[i];
            enq[i].target = upd_target[i];
        end
    end

    assign pop = (count != '0) && !btb_stall;

    btb_upd_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk_i       (clk),
        .rst_i       (rst),
        .enq_valid_i (upd_valid & {2{upd_ready}}),
        .enq_i       (enq),
        .deq_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!drain_req)                       state_d = ST_RUN;
                else if ((count == '0) && !w_en_q)    state_d = ST_DONE;
            end
            ST_DONE:  if (!drain_req) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        upd_ready  = (state_q == ST_RUN) && (count <= CW'(QDEPTH - 2));
        drain_done = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_en_q <= 1'b0;
            pc_q   <= '0;
            tgt_q  <= '0;
        end else begin
            w_en_q <= pop;
            if (pop) begin
                pc_q  <= head.pc;
                tgt_q <= head.target;
            end
        end
    end

    assign btb_w_en        = w_en_q;
    assign btb_commit_pc   = pc_q;
    assign btb_target_addr = tgt_q;
    assign q_count         = count;

endmodule
